fetch_pc_unit: RTL and testbench

//   Front-end fetch unit that consumes the branch/jump redirect target produced in EX.
//   It holds the fetch PC, issues in-order word requests to instruction memory (req/gnt + rvalid),
//   and buffers returned words with their PC for decode (valid/ready).
//   On a redirect it flushes buffered words, squashes in-flight responses and restarts at the target.

---
 rtl/fetch_pc_unit_if.sv | 58 +++++
 rtl/fetch_pc_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Bus bundle for the fetch PC unit: redirect/stall control from the pipeline, the
// instruction-memory req/gnt/rvalid channel and the decode-side valid/ready channel.
// The misalign_out signal only exists when FETCH_MISALIGN_CHECK_EN is defined.
interface fetch_pc_unit_if;
    logic        redirect_valid_in;
    logic [31:0] redirect_pc_in;
    logic        stall_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_ready_in;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_out;
`endif

    // Fetch unit side
    modport master (
`ifdef FETCH_MISALIGN_CHECK_EN
        output misalign_out,
`endif
        input  redirect_valid_in,
        input  redirect_pc_in,
        input  stall_in,
        output imem_req_out,
        output imem_addr_out,
        input  imem_gnt_in,
        input  imem_rvalid_in,
        input  imem_rdata_in,
        output instr_valid_out,
        output instr_out,
        output instr_pc_out,
        input  instr_ready_in
    );

    // Pipeline / memory / decode side
    modport slave (
`ifdef FETCH_MISALIGN_CHECK_EN
        input  misalign_out,
`endif
        output redirect_valid_in,
        output redirect_pc_in,
        output stall_in,
        input  imem_req_out,
        input  imem_addr_out,
        output imem_gnt_in,
        output imem_rvalid_in,
        output imem_rdata_in,
        input  instr_valid_out,
        input  instr_out,
        input  instr_pc_out,
        output instr_ready_in
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: holds the fetch PC, issues in-order word requests to instruction
// memory, buffers returned words with their PC for decode and restarts at the
// redirect target from EX, squashing everything fetched before the redirect.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (reject misaligned redirects and
// pulse misalign_out); when undefined the low two target bits are cleared.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH   = 2,
    parameter int unsigned MAX_OUTSTND = 2
) (
    input logic             clk,
    input logic             rst_n,
    fetch_pc_unit_if.master bus
);
    localparam int unsigned BufAw    = $clog2(BUF_DEPTH);
    // In-flight PC FIFO sized to the next power of two above MAX_OUTSTND (<= 3)
    localparam int unsigned PcfDepth = 4;

    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic           req_en_q;
    logic [1:0]     outst_q, outst_d;
    logic [1:0]     discard_q, discard_d;
    logic [31:0]    pcf_mem_q [PcfDepth];
    logic [1:0]     pcf_wr_q, pcf_rd_q;
    logic [31:0]    buf_instr_q [BUF_DEPTH];
    logic [31:0]    buf_pc_q [BUF_DEPTH];
    logic [BufAw:0] buf_wr_q, buf_rd_q, buf_count;
    logic           redirect, req, fire, rv, drop, push, pop, buf_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic           misalign_q, misalign_d;
`endif

    // Request/response bookkeeping and next fetch PC
    always_comb begin
        redirect  = bus.redirect_valid_in;
        buf_count = buf_wr_q - buf_rd_q;
        buf_valid = (buf_count != '0);
        // Reserve a buffer slot for every outstanding request so responses never overflow
        req       = req_en_q && !bus.stall_in && !redirect
                    && (32'(outst_q) < MAX_OUTSTND)
                    && ((32'(outst_q) + 32'(buf_count)) < BUF_DEPTH);
        fire      = req && bus.imem_gnt_in;
        // A response with nothing outstanding is a protocol error and is ignored
        rv        = bus.imem_rvalid_in && (outst_q != 2'd0);
        drop      = rv && (discard_q != 2'd0);
        push      = rv && !drop && !redirect;
        pop       = buf_valid && bus.instr_ready_in && !redirect;
        outst_d   = outst_q + {1'b0, fire} - {1'b0, rv};
        // On redirect every request still in flight after this cycle is stale
        discard_d = redirect ? outst_d : (discard_q - {1'b0, drop});
        fetch_pc_d = fetch_pc_q;
        if (fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_d = redirect && (bus.redirect_pc_in[1:0] != 2'b00);
        if (redirect && !misalign_d) begin
            fetch_pc_d = bus.redirect_pc_in;
        end
`else
        if (redirect) begin
            fetch_pc_d = bus.redirect_pc_in & 32'hFFFF_FFFC;
        end
`endif
    end

    // Control state: fetch PC, request enable, outstanding and discard counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_en_q   <= 1'b0;
            outst_q    <= 2'd0;
            discard_q  <= 2'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_en_q   <= 1'b1;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // One-cycle registered pulse for a rejected misaligned redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

    // In-flight PC FIFO: issue PC pushed on grant, popped on each response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PcfDepth); i++) begin
                pcf_mem_q[i] <= 32'h0;
            end
            pcf_wr_q <= 2'd0;
            pcf_rd_q <= 2'd0;
        end else begin
            if (fire) begin
                pcf_mem_q[pcf_wr_q] <= fetch_pc_q;
                pcf_wr_q            <= pcf_wr_q + 2'd1;
            end
            if (rv) begin
                pcf_rd_q <= pcf_rd_q + 2'd1;
            end
        end
    end

    // Instruction buffer: write returned words, advance head on pop, empty on redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_instr_q[i] <= 32'h0;
                buf_pc_q[i]    <= 32'h0;
            end
            buf_wr_q <= '0;
            buf_rd_q <= '0;
        end else begin
            if (push) begin
                buf_instr_q[buf_wr_q[BufAw-1:0]] <= bus.imem_rdata_in;
                buf_pc_q[buf_wr_q[BufAw-1:0]]    <= pcf_mem_q[pcf_rd_q];
                buf_wr_q                         <= buf_wr_q + 1'b1;
            end
            if (redirect) begin
                buf_rd_q <= buf_wr_q;
            end else if (pop) begin
                buf_rd_q <= buf_rd_q + 1'b1;
            end
        end
    end

    assign bus.imem_req_out    = req;
    assign bus.imem_addr_out   = fetch_pc_q;
    assign bus.instr_valid_out = buf_valid;
    assign bus.instr_out       = buf_instr_q[buf_rd_q[BufAw-1:0]];
    assign bus.instr_pc_out    = buf_pc_q[buf_rd_q[BufAw-1:0]];
`ifdef FETCH_MISALIGN_CHECK_EN
    assign bus.misalign_out    = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: a memory responder with random latency,
// and a transaction-level reference model (epoch-tagged requests, queue of expected
// decode entries) compared against the DUT each cycle.
module tb_fetch_pc_unit;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          BUF_DEPTH   = 2;
    localparam int          MAX_OUTSTND = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(
        .RESET_PC   (RESET_PC),
        .BUF_DEPTH  (BUF_DEPTH),
        .MAX_OUTSTND(MAX_OUTSTND)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    req_t        inflight[$];
    ent_t        expq[$];
    logic [31:0] m_pc;
    bit          m_mis;
    int          epoch;
    int          cyc;
    int          vectors;
    int          miscompares;

    logic        o_req, o_valid, o_mis;
    logic [31:0] o_addr, o_instr, o_pc;
    bit          e_req, e_valid, e_mis;
    logic [31:0] e_addr;
    ent_t        e_head;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
    endfunction

    // Drive one cycle, sample outputs, then advance the reference model
    task automatic step(input bit redir, input logic [31:0] rpc, input bit stall_v,
                        input bit ready_v, input bit gnt_v, input int lat);
        req_t r;
        req_t g;
        ent_t n;
        bit   rv;
        @(negedge clk);
        cyc++;
        bus.redirect_valid_in = redir;
        bus.redirect_pc_in    = rpc;
        bus.stall_in          = stall_v;
        bus.instr_ready_in    = ready_v;
        bus.imem_gnt_in       = 1'b0;
        rv = (inflight.size() > 0) && (inflight[0].due <= cyc);
        bus.imem_rvalid_in    = rv;
        bus.imem_rdata_in     = rv ? word_of(inflight[0].addr) : $urandom;
        #1;
        o_req   = bus.imem_req_out;
        o_addr  = bus.imem_addr_out;
        o_valid = bus.instr_valid_out;
        o_instr = bus.instr_out;
        o_pc    = bus.instr_pc_out;
`ifdef FETCH_MISALIGN_CHECK_EN
        o_mis   = bus.misalign_out;
`else
        o_mis   = 1'b0;
`endif
        e_req   = !stall_v && !redir && (inflight.size() < MAX_OUTSTND)
                  && ((inflight.size() + expq.size()) < BUF_DEPTH);
        e_addr  = m_pc;
        e_valid = (expq.size() != 0);
        if (e_valid) e_head = expq[0];
        e_mis   = m_mis;
        bus.imem_gnt_in = gnt_v && o_req;
        #1;
        if (rv) r = inflight.pop_front();
        m_mis = 1'b0;
        if (redir) begin
            expq.delete();
            epoch++;
`ifdef FETCH_MISALIGN_CHECK_EN
            m_mis = (rpc[1:0] != 2'b00);
            if (!m_mis) m_pc = rpc;
`else
            m_pc = {rpc[31:2], 2'b00};
`endif
        end else begin
            if (e_valid && ready_v) void'(expq.pop_front());
            if (rv && r.epoch == epoch) begin
                n.pc   = r.addr;
                n.word = word_of(r.addr);
                expq.push_back(n);
            end
            if (gnt_v && o_req) begin
                g.addr  = m_pc;
                g.epoch = epoch;
                g.due   = cyc + lat;
                inflight.push_back(g);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Stall fetch and drain everything so directed tests start from a known state
    task automatic quiesce();
        int n = 0;
        while ((inflight.size() != 0 || expq.size() != 0) && n < 60) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1);
            n++;
        end
        vectors++;
        if (inflight.size() != 0 || expq.size() != 0) begin
            miscompares++;
            $display("FAIL quiesce_timeout: got %0d pending want 0",
                     inflight.size() + expq.size());
        end
    endtask

    // After a redirect, wait (bounded) for the first visible head and check it
    task automatic expect_first(input string name, input logic [31:0] tgt);
        bit found = 1'b0;
        for (int i = 0; i < 25 && !found; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
            if (o_valid) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL %s_timeout: got no valid want pc %h", name, tgt);
        end else begin
            vectors++;
            if (o_pc !== tgt) begin
                miscompares++;
                $display("FAIL %s_pc: got %h want %h", name, o_pc, tgt);
            end
            vectors++;
            if (o_instr !== word_of(tgt)) begin
                miscompares++;
                $display("FAIL %s_instr: got %h want %h", name, o_instr, word_of(tgt));
            end
        end
    endtask

    task automatic test_reset();
        bus.redirect_valid_in = 1'b0;
        bus.redirect_pc_in    = 32'h0;
        bus.stall_in          = 1'b0;
        bus.imem_gnt_in       = 1'b0;
        bus.imem_rvalid_in    = 1'b0;
        bus.imem_rdata_in     = 32'h0;
        bus.instr_ready_in    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.imem_req_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_req: got %b want 0", bus.imem_req_out);
        end
        vectors++;
        if (bus.instr_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b want 0", bus.instr_valid_out);
        end
        vectors++;
        if (bus.instr_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_instr: got %h want 0", bus.instr_out);
        end
        vectors++;
        if (bus.instr_pc_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_pc: got %h want 0", bus.instr_pc_out);
        end
        vectors++;
        if (bus.imem_addr_out !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_addr: got %h want %h", bus.imem_addr_out, RESET_PC);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        vectors++;
        if (bus.misalign_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_misalign: got %b want 0", bus.misalign_out);
        end
`endif
        repeat (2) @(negedge clk);
        inflight.delete();
        expq.delete();
        m_pc  = RESET_PC;
        m_mis = 1'b0;
        rst_n = 1'b1;
    endtask

    // gnt always, 1-cycle latency, ready=1: sequential addresses and PCs
    task automatic test_stream();
        int grants = 0;
        int pops = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
            if (k < 2) begin
                vectors++;
                if (o_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_early_valid: got %b want 0 at step %0d", o_valid, k);
                end
            end
            if (k == 2) begin
                vectors++;
                if (o_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_latency: got valid %b want 1 at step 2", o_valid);
                end
            end
            if (o_req) begin
                vectors++;
                if (o_addr !== RESET_PC + 32'(4 * grants)) begin
                    miscompares++;
                    $display("FAIL stream_addr: got %h want %h", o_addr,
                             RESET_PC + 32'(4 * grants));
                end
                grants++;
            end
            if (o_valid) begin
                vectors++;
                if (o_pc !== RESET_PC + 32'(4 * pops) ||
                    o_instr !== word_of(RESET_PC + 32'(4 * pops))) begin
                    miscompares++;
                    $display("FAIL stream_head: got pc %h instr %h want pc %h", o_pc, o_instr,
                             RESET_PC + 32'(4 * pops));
                end
                pops++;
            end
        end
        vectors++;
        if (pops < 4) begin
            miscompares++;
            $display("FAIL stream_throughput: got %0d pops want >= 4", pops);
        end
    endtask

    // Decode stalled: buffer fills to exactly BUF_DEPTH, then drains in order
    task automatic test_backpressure();
        int          pops = 0;
        logic [31:0] first_pc;
        quiesce();
        first_pc = m_pc;
        for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1);
        vectors++;
        if (o_req !== 1'b0 || o_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_full: got req %b valid %b want req 0 valid 1", o_req, o_valid);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1);
            if (o_valid) begin
                vectors++;
                if (o_pc !== first_pc + 32'(4 * pops)) begin
                    miscompares++;
                    $display("FAIL bp_order: got %h want %h", o_pc, first_pc + 32'(4 * pops));
                end
                pops++;
            end
        end
        vectors++;
        if (pops != BUF_DEPTH) begin
            miscompares++;
            $display("FAIL bp_count: got %0d want %0d", pops, BUF_DEPTH);
        end
    endtask

    // Redirect with two slow responses outstanding: both squashed
    task automatic test_redirect();
        quiesce();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5);
        vectors++;
        if (inflight.size() != 2 || o_req !== 1'b1) begin
            miscompares++;
            $display("FAIL redir_setup: got req %b want 1 with 2 outstanding", o_req);
        end
        step(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 1);
        vectors++;
        if (o_req !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_req: got %b want 0 in redirect cycle", o_req);
        end
        expect_first("redir", 32'h0000_0100);
    endtask

    // Redirect in the same cycle as a response arrives, with another still in flight
    task automatic test_redirect_coincident();
        quiesce();
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2);
        step(1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b1, 1);
        expect_first("coinc", 32'h0000_0200);
    endtask

    // PC increment wraps from the top of the address space
    task automatic test_wrap();
        quiesce();
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
        vectors++;
        if (o_req !== 1'b1 || o_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_top: got req %b addr %h want 1 fffffffc", o_req, o_addr);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
        vectors++;
        if (o_req !== 1'b1 || o_addr !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL wrap_zero: got req %b addr %h want 1 00000000", o_req, o_addr);
        end
        quiesce();
    endtask

    // Misaligned redirect target
    task automatic test_misalign();
        logic [31:0] old_pc;
        quiesce();
        old_pc = m_pc;
        step(1'b1, 32'h0000_0102, 1'b0, 1'b1, 1'b0, 1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1);
`ifdef FETCH_MISALIGN_CHECK_EN
        vectors++;
        if (o_mis !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_pulse: got %b want 1", o_mis);
        end
        vectors++;
        if (o_addr !== old_pc) begin
            miscompares++;
            $display("FAIL misalign_pc: got %h want %h", o_addr, old_pc);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1);
        vectors++;
        if (o_mis !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_width: got %b want 0", o_mis);
        end
`else
        vectors++;
        if (o_addr !== 32'h0000_0100) begin
            miscompares++;
            $display("FAIL misalign_force: got %h want 00000100 (old %h)", o_addr, old_pc);
        end
`endif
    endtask

    // Random traffic compared cycle by cycle against the reference model
    task automatic test_random();
        bit          redir;
        logic [31:0] tgt;
        for (int k = 0; k < 3000; k++) begin
            redir = ($urandom_range(99) < 4);
            tgt   = $urandom;
            if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000F);
            step(redir, tgt, ($urandom_range(99) < 20), ($urandom_range(99) < 70),
                 ($urandom_range(99) < 70), $urandom_range(3, 1));
            vectors++;
            if (o_req !== e_req) begin
                miscompares++;
                $display("FAIL rand_req: cyc %0d got %b want %b", cyc, o_req, e_req);
            end
            if (e_req) begin
                vectors++;
                if (o_addr !== e_addr) begin
                    miscompares++;
                    $display("FAIL rand_addr: cyc %0d got %h want %h", cyc, o_addr, e_addr);
                end
            end
            vectors++;
            if (o_valid !== e_valid) begin
                miscompares++;
                $display("FAIL rand_valid: cyc %0d got %b want %b", cyc, o_valid, e_valid);
            end
            if (e_valid && o_valid) begin
                vectors++;
                if (o_pc !== e_head.pc || o_instr !== e_head.word) begin
                    miscompares++;
                    $display("FAIL rand_head: cyc %0d got %h/%h want %h/%h", cyc, o_pc,
                             o_instr, e_head.pc, e_head.word);
                end
            end
            vectors++;
            if (o_mis !== e_mis) begin
                miscompares++;
                $display("FAIL rand_misalign: cyc %0d got %b want %b", cyc, o_mis, e_mis);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        epoch       = 0;
        m_pc        = RESET_PC;
        m_mis       = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_coincident();
        test_wrap();
        test_misalign();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
